// File: rtl/ser_pkg.sv
// Shared encodings for the serial transmitter: FSM states and line levels.
package ser_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Level driven on sout when no frame is in progress (also the stop symbol).
    localparam logic IDLE_LVL  = 1'b1;
    // Level of the start symbol.
    localparam logic START_LVL = 1'b0;

    // Supported data word widths.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/ser_tx_if.sv
// Handshake bundle between a word source / serial receiver and ser_tx.
interface ser_tx_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             sval;
    logic             frame;
    logic             busy;
    logic             done;
    logic             ovr;

    // Side that supplies words and consumes serial symbols.
    modport master (
        output load, din, ready,
        input  sout, sval, frame, busy, done, ovr
    );

    // The transmitter itself.
    modport slave (
        input  load, din, ready,
        output sout, sval, frame, busy, done, ovr
    );
endinterface

// File: rtl/ser_bitcnt.sv
// Data-bit counter: clear, count enable and terminal count at WIDTH-1.
module ser_bitcnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic r,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_q;

    // Counter never wraps: the FSM leaves DATA once tc_o is seen with en_i.
    always_ff @(posedge clk or negedge r) begin
        if (!r)         cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + CW'(1);
    end

    assign tc_o = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: start, WIDTH data bits LSB first,
// even parity, stop. Symbols advance only when the receiver is ready.
module ser_tx
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     r,
    ser_tx_if.slave  bus
);
    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             par_q;
    logic             sout_q;
    logic             sval_q;
    logic             frame_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    assign cnt_clr = (state_q == S_IDLE) && bus.load;
    assign cnt_en  = (state_q == S_DATA) && bus.ready;

    ser_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk   (clk),
        .r     (r),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Frame FSM; every output is set alongside the state it belongs to.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            par_q   <= 1'b0;
            sout_q  <= IDLE_LVL;
            sval_q  <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        shreg_q <= bus.din;
                        par_q   <= ^bus.din;
                        ovr_q   <= 1'b0;
                        state_q <= S_START;
                        sout_q  <= START_LVL;
                        sval_q  <= 1'b1;
                        frame_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bus.ready) begin
                        state_q <= S_DATA;
                        sout_q  <= shreg_q[0];
                        frame_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bus.ready) begin
                        shreg_q <= shreg_q >> 1;
                        if (cnt_tc) begin
                            state_q <= S_PAR;
                            sout_q  <= par_q;
                        end else begin
                            sout_q  <= shreg_q[1];
                        end
                    end
                end
                S_PAR: begin
                    if (bus.ready) begin
                        state_q <= S_STOP;
                        sout_q  <= IDLE_LVL;
                    end
                end
                S_STOP: begin
                    if (bus.ready) begin
                        state_q <= S_IDLE;
                        sout_q  <= IDLE_LVL;
                        sval_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sout_q  <= IDLE_LVL;
                    sval_q  <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
            // A load outside IDLE is dropped but remembered; the IDLE
            // branch above is the only place that clears it.
            if (bus.load && (state_q != S_IDLE)) ovr_q <= 1'b1;
        end
    end

    assign bus.sout  = sout_q;
    assign bus.sval  = sval_q;
    assign bus.frame = frame_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx (WIDTH=8) with hand-computed symbol streams.
module tb_ser_tx;
    logic clk;
    logic r;
    int   tests;
    int   fails;

    ser_tx_if #(.WIDTH(8)) bus ();

    ser_tx #(.WIDTH(8)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Symbol streams, bit i = sout during symbol i (start, d0..d7, parity, stop).
    localparam logic [10:0] EV_A5 = 11'b10101001010;
    localparam logic [10:0] EV_01 = 11'b11000000010;
    localparam logic [10:0] EV_3C = 11'b10001111000;

    // Send one word and check every symbol; optional stall and stray load.
    task automatic frame_run(input string tag, input logic [7:0] d, input logic [10:0] ev,
                             input int stall_at, input int stall_n, input int ovr_at);
        int dn;
        dn = 0;
        bus.din   = d;
        bus.load  = 1'b1;
        bus.ready = 1'b1;
        step();
        bus.load = 1'b0;
        bus.din  = ~d;
        chk($sformatf("%s ovr_clr", tag), bus.ovr, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i == stall_at) begin
                bus.ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk($sformatf("%s stall sout[%0d.%0d]", tag, i, s), bus.sout, ev[i]);
                    chk($sformatf("%s stall sval[%0d.%0d]", tag, i, s), bus.sval, 1'b1);
                    step();
                end
                bus.ready = 1'b1;
            end
            if (i == ovr_at) begin
                bus.load = 1'b1;
                bus.din  = 8'hFF;
            end
            chk($sformatf("%s sout[%0d]", tag, i), bus.sout, ev[i]);
            chk($sformatf("%s sval[%0d]", tag, i), bus.sval, 1'b1);
            chk($sformatf("%s busy[%0d]", tag, i), bus.busy, 1'b1);
            chk($sformatf("%s frame[%0d]", tag, i), bus.frame, i == 0);
            if (bus.done) dn++;
            step();
            bus.load = 1'b0;
        end
        chk($sformatf("%s done_in_frame", tag), dn == 0, 1'b1);
        chk($sformatf("%s idle busy", tag), bus.busy, 1'b0);
        chk($sformatf("%s idle sval", tag), bus.sval, 1'b0);
        chk($sformatf("%s idle sout", tag), bus.sout, 1'b1);
        chk($sformatf("%s done", tag), bus.done, 1'b1);
        chk($sformatf("%s ovr", tag), bus.ovr, ovr_at >= 0);
        step();
        chk($sformatf("%s done_clear", tag), bus.done, 1'b0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        r         = 1'b0;
        bus.load  = 1'b0;
        bus.din   = '0;
        bus.ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst sout", bus.sout, 1'b1);
        chk("rst sval", bus.sval, 1'b0);
        chk("rst frame", bus.frame, 1'b0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst ovr", bus.ovr, 1'b0);
        r = 1'b1;
        bus.ready = 1'b1;
        step();
        chk("idle busy", bus.busy, 1'b0);

        // Plain frames, parity 0 and parity 1
        frame_run("a5", 8'hA5, EV_A5, -1, 0, -1);
        frame_run("01", 8'h01, EV_01, -1, 0, -1);
        // Three-cycle stall on the 4th data bit
        frame_run("stall", 8'hA5, EV_A5, 4, 3, -1);
        // Stray load during DATA sets ovr, frame unchanged
        frame_run("ovr", 8'hA5, EV_A5, -1, 0, 3);
        chk("ovr held in idle", bus.ovr, 1'b1);
        // Next accepted load clears ovr (checked at its START)
        frame_run("clr", 8'h01, EV_01, -1, 0, -1);

        // Reset during parity symbol
        bus.din  = 8'hA5;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (9) step();
        chk("par sval before rst", bus.sval, 1'b1);
        #2 r = 1'b0;
        #1;
        chk("midrst sout", bus.sout, 1'b1);
        chk("midrst sval", bus.sval, 1'b0);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        #2 r = 1'b1;
        frame_run("3c", 8'h3C, EV_3C, -1, 0, -1);

        // Load held high: back-to-back frames with one IDLE cycle between
        bus.din  = 8'hA5;
        bus.load = 1'b1;
        step();
        chk("b2b frame", bus.frame, 1'b1);
        chk("b2b ovr0", bus.ovr, 1'b0);
        step();
        chk("b2b ovr1", bus.ovr, 1'b1);
        chk("b2b d0", bus.sout, 1'b1);
        repeat (10) step();
        chk("b2b gap busy", bus.busy, 1'b0);
        chk("b2b gap done", bus.done, 1'b1);
        chk("b2b gap sval", bus.sval, 1'b0);
        step();
        chk("b2b restart busy", bus.busy, 1'b1);
        chk("b2b restart frame", bus.frame, 1'b1);
        chk("b2b restart ovr", bus.ovr, 1'b0);
        step();
        chk("b2b second ovr", bus.ovr, 1'b1);
        bus.load = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!bus.busy) break;
            step();
        end
        chk("b2b drain busy", bus.busy, 1'b0);
        chk("b2b drain done", bus.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
